atm_pin_fsm: RTL and testbench

Parametrised ATM PIN-entry controller. It accepts a PIN of PIN_LEN digits, DIGIT_W bits each, from the switch front-end. A matching entry grants a cash dispense. MAX_TRIES failed entries permanently lock the machine (card retained/destroyed). A cycle-count inactivity timeout aborts partial entries. State code drives the top-level 7-segment/LED display.

---
 rtl/atm_pin_fsm_if.sv | 30 +++
 rtl/atm_pin_fsm.sv | 117 +++++++++++
 tb/tb_atm_pin_fsm.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_pin_fsm_if.sv
// Bus between the ATM switch front-end and the PIN-entry controller.
// digit_valid is a valid-only strobe with no ready: every valid digit seen in CARD or ENTRY is consumed on that edge.
interface atm_pin_fsm_if #(
  parameter int DIGIT_W   = 4,
  parameter int PIN_LEN   = 4,
  parameter int MAX_TRIES = 3
);
  localparam int POS_W   = $clog2(PIN_LEN + 1);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  logic                       card;
  logic [DIGIT_W-1:0]         digit;
  logic                       digit_valid;
  logic [PIN_LEN*DIGIT_W-1:0] pin_ref;
  logic                       dispense;
  logic                       destroyed;
  logic [2:0]                 state;
  logic [POS_W-1:0]           pos;
  logic [TRIES_W-1:0]         tries;

  modport master (
    output card, digit, digit_valid, pin_ref,
    input  dispense, destroyed, state, pos, tries
  );

  modport slave (
    input  card, digit, digit_valid, pin_ref,
    output dispense, destroyed, state, pos, tries
  );
endinterface

// File: rtl/atm_pin_fsm.sv
// ATM PIN-entry controller: collects PIN_LEN digits, grants on a full match,
// locks permanently after MAX_TRIES failures, and drops stale partial entries after an idle timeout.
module atm_pin_fsm #(
  parameter int DIGIT_W   = 4,
  parameter int PIN_LEN   = 4,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 16
) (
  input logic          clk_2,
  input logic          reset,
  atm_pin_fsm_if.slave bus
);
  localparam int POS_W   = $clog2(PIN_LEN + 1);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CARD    = 3'd1,
    S_ENTRY   = 3'd2,
    S_GRANTED = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               bad_q, bad_d;

  logic [DIGIT_W-1:0] exp_digit;
  logic               any_bad;
  logic               last_digit;

  assign exp_digit  = DIGIT_W'(bus.pin_ref >> (DIGIT_W * int'(pos_q)));
  assign any_bad    = bad_q | (bus.digit != exp_digit);
  assign last_digit = (pos_q == POS_W'(PIN_LEN - 1));

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      tries_q <= '0;
      timer_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tries_d = tries_q;
    timer_d = timer_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        if (bus.card) state_d = S_CARD;
      end
      S_CARD, S_ENTRY: begin
        if (!bus.card) begin
          state_d = S_IDLE;
          pos_d   = '0;
          bad_d   = 1'b0;
          timer_d = '0;
        end else if (bus.digit_valid) begin
          timer_d = '0;
          if (last_digit) begin
            // The wrong digit is only revealed once the whole PIN is in.
            pos_d = '0;
            bad_d = 1'b0;
            if (!any_bad) begin
              state_d = S_GRANTED;
              tries_d = '0;
            end else begin
              tries_d = tries_q + TRIES_W'(1);
              state_d = (tries_q == TRIES_W'(MAX_TRIES - 1)) ? S_LOCKED : S_CARD;
            end
          end else begin
            state_d = S_ENTRY;
            pos_d   = pos_q + POS_W'(1);
            bad_d   = any_bad;
          end
        end else if (state_q == S_ENTRY) begin
          if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
            state_d = S_CARD;
            pos_d   = '0;
            bad_d   = 1'b0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end
      S_GRANTED: begin
        if (!bus.card) state_d = S_IDLE;
      end
      S_LOCKED: begin
        state_d = S_LOCKED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.state     = state_q;
  assign bus.pos       = pos_q;
  assign bus.tries     = tries_q;
  assign bus.dispense  = (state_q == S_GRANTED);
  assign bus.destroyed = (state_q == S_LOCKED);
endmodule

// File: tb/tb_atm_pin_fsm.sv
// Bench for atm_pin_fsm: two instances (default and 6x3-bit/1-try) run against a queue-based reference
// model, with directed scenarios followed by randomized traffic.
module tb_atm_pin_fsm;
  localparam int A_DW = 4, A_PL = 4, A_MT = 3;
  localparam int B_DW = 3, B_PL = 6, B_MT = 1;
  localparam int TO   = 16;

  // clock / reset
  logic clk_2 = 1'b0;
  logic reset = 1'b0;
  always #5 clk_2 = ~clk_2;

  atm_pin_fsm_if #(.DIGIT_W(A_DW), .PIN_LEN(A_PL), .MAX_TRIES(A_MT)) if_a ();
  atm_pin_fsm_if #(.DIGIT_W(B_DW), .PIN_LEN(B_PL), .MAX_TRIES(B_MT)) if_b ();

  atm_pin_fsm #(.DIGIT_W(A_DW), .PIN_LEN(A_PL), .MAX_TRIES(A_MT), .TIMEOUT(TO)) dut_a (
    .clk_2(clk_2), .reset(reset), .bus(if_a)
  );
  atm_pin_fsm #(.DIGIT_W(B_DW), .PIN_LEN(B_PL), .MAX_TRIES(B_MT), .TIMEOUT(TO)) dut_b (
    .clk_2(clk_2), .reset(reset), .bus(if_b)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: state code, failed tries, idle count, per-digit match results of current attempt
  int m_state [2];
  int m_tries [2];
  int m_idle  [2];
  bit m_match [2][$];
  int p_len   [2];
  int d_w     [2];
  int t_max   [2];

  function automatic int ref_digit(int k, logic [31:0] pin, int i);
    return int'((pin >> (i * d_w[k])) & ((32'd1 << d_w[k]) - 32'd1));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0;
      m_tries[k] = 0;
      m_idle[k]  = 0;
      m_match[k].delete();
    end
  endtask

  task automatic model_step(int k, bit card, bit dv, int dig, logic [31:0] pin);
    int all_ok;
    case (m_state[k])
      0: if (card) m_state[k] = 1;
      1, 2: begin
        if (!card) begin
          m_state[k] = 0;
          m_match[k].delete();
          m_idle[k] = 0;
        end else if (dv) begin
          m_match[k].push_back(dig == ref_digit(k, pin, m_match[k].size()));
          m_idle[k] = 0;
          if (m_match[k].size() == p_len[k]) begin
            all_ok = 1;
            for (int i = 0; i < m_match[k].size(); i++) if (!m_match[k][i]) all_ok = 0;
            m_match[k].delete();
            if (all_ok == 1) begin
              m_state[k] = 3;
              m_tries[k] = 0;
            end else begin
              m_tries[k]++;
              m_state[k] = (m_tries[k] == t_max[k]) ? 4 : 1;
            end
          end else begin
            m_state[k] = 2;
          end
        end else if (m_state[k] == 2) begin
          m_idle[k]++;
          if (m_idle[k] == TO) begin
            m_state[k] = 1;
            m_match[k].delete();
            m_idle[k] = 0;
          end
        end
      end
      3: if (!card) m_state[k] = 0;
      default: ;
    endcase
  endtask

  // scoreboard
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, "_a_state"},     32'(if_a.state),     32'(m_state[0]));
    check({tag, "_a_pos"},       32'(if_a.pos),       32'(m_match[0].size()));
    check({tag, "_a_tries"},     32'(if_a.tries),     32'(m_tries[0]));
    check({tag, "_a_dispense"},  32'(if_a.dispense),  32'(m_state[0] == 3));
    check({tag, "_a_destroyed"}, 32'(if_a.destroyed), 32'(m_state[0] == 4));
    check({tag, "_b_state"},     32'(if_b.state),     32'(m_state[1]));
    check({tag, "_b_pos"},       32'(if_b.pos),       32'(m_match[1].size()));
    check({tag, "_b_tries"},     32'(if_b.tries),     32'(m_tries[1]));
    check({tag, "_b_dispense"},  32'(if_b.dispense),  32'(m_state[1] == 3));
    check({tag, "_b_destroyed"}, 32'(if_b.destroyed), 32'(m_state[1] == 4));
  endtask

  // drivers
  task automatic drive_a(bit c, bit v, int d);
    if_a.card        = c;
    if_a.digit_valid = v;
    if_a.digit       = A_DW'(d);
  endtask

  task automatic drive_b(bit c, bit v, int d);
    if_b.card        = c;
    if_b.digit_valid = v;
    if_b.digit       = B_DW'(d);
  endtask

  task automatic cycle(string tag);
    model_step(0, if_a.card, if_a.digit_valid, int'(if_a.digit), 32'(if_a.pin_ref));
    model_step(1, if_b.card, if_b.digit_valid, int'(if_b.digit), 32'(if_b.pin_ref));
    @(posedge clk_2);
    #1;
    check_all(tag);
  endtask

  // reset asserted between edges; outputs must clear before any clock edge
  task automatic do_reset(string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic enter_a(bit c, int d0, int d1, int d2, int d3, string tag);
    drive_a(c, 1, d0); cycle(tag);
    drive_a(c, 1, d1); cycle(tag);
    drive_a(c, 1, d2); cycle(tag);
    drive_a(c, 1, d3); cycle(tag);
    drive_a(c, 0, 0);
  endtask

  initial begin
    int burst [2];
    int d;
    bit c, v;
    p_len[0] = A_PL; d_w[0] = A_DW; t_max[0] = A_MT;
    p_len[1] = B_PL; d_w[1] = B_DW; t_max[1] = B_MT;
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    if_a.pin_ref = 16'h7311;
    if_b.pin_ref = 18'($urandom);
    model_reset();
    do_reset("reset0");

    // 1: correct PIN granted, card removal returns to IDLE
    drive_a(1, 0, 0); cycle("t1_card");
    enter_a(1, 1, 1, 3, 7, "t1_dig");
    check("t1_granted_state", 32'(if_a.state), 32'd3);
    check("t1_dispense", 32'(if_a.dispense), 32'd1);
    drive_a(1, 1, 5); cycle("t1_ignore");
    drive_a(0, 0, 0); cycle("t1_out");
    check("t1_idle", 32'(if_a.state), 32'd0);

    // 2: wrong first digit, then correct
    drive_a(1, 0, 0); cycle("t2_card");
    enter_a(1, 2, 1, 3, 7, "t2_bad");
    check("t2_back_card", 32'(if_a.state), 32'd1);
    check("t2_tries1", 32'(if_a.tries), 32'd1);
    enter_a(1, 1, 1, 3, 7, "t2_good");
    check("t2_tries0", 32'(if_a.tries), 32'd0);
    drive_a(0, 0, 0); cycle("t2_out");

    // 3: three failures across reinserts -> LOCKED, sticky until reset
    for (int n = 0; n < 3; n++) begin
      drive_a(1, 0, 0); cycle("t3_card");
      enter_a(1, 2, 1, 3, 7, "t3_bad");
      drive_a(0, 0, 0); cycle("t3_out");
    end
    check("t3_locked", 32'(if_a.state), 32'd4);
    check("t3_destroyed", 32'(if_a.destroyed), 32'd1);
    check("t3_tries", 32'(if_a.tries), 32'd3);
    drive_a(1, 0, 0); cycle("t3_stick");
    enter_a(1, 1, 1, 3, 7, "t3_stick_pin");
    check("t3_still_locked", 32'(if_a.state), 32'd4);
    do_reset("t3_reset");
    check("t3_reset_state", 32'(if_a.state), 32'd0);

    // 4: idle timeout discards partial entry without counting a try
    drive_a(1, 0, 0); cycle("t4_card");
    drive_a(1, 1, 1); cycle("t4_d0");
    drive_a(1, 1, 1); cycle("t4_d1");
    drive_a(1, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle("t4_idle");
    check("t4_pre_timeout", 32'(if_a.state), 32'd2);
    cycle("t4_timeout");
    check("t4_timed_out", 32'(if_a.state), 32'd1);
    enter_a(1, 1, 1, 3, 7, "t4_good");
    check("t4_granted", 32'(if_a.state), 32'd3);
    drive_a(0, 0, 0); cycle("t4_out");

    // 5: card pull beats the last correct digit; async reset mid-entry
    drive_a(1, 0, 0); cycle("t5_card");
    drive_a(1, 1, 1); cycle("t5_d");
    drive_a(1, 1, 1); cycle("t5_d");
    drive_a(1, 1, 3); cycle("t5_d");
    drive_a(0, 1, 7); cycle("t5_pull");
    check("t5_no_grant", 32'(if_a.state), 32'd0);
    drive_a(1, 0, 0); cycle("t5_card2");
    drive_a(1, 1, 1); cycle("t5_d");
    drive_a(1, 1, 1); cycle("t5_d");
    drive_a(0, 0, 0);
    do_reset("t5_async");

    // 6: 6-digit, 3-bit, single-try instance
    drive_b(1, 0, 0); cycle("t6_card");
    for (int i = 0; i < B_PL; i++) begin
      d = ref_digit(1, 32'(if_b.pin_ref), i);
      if (i == B_PL - 1) d = d ^ 1;
      drive_b(1, 1, d); cycle("t6_bad");
    end
    check("t6_locked", 32'(if_b.state), 32'd4);
    drive_b(0, 0, 0);
    do_reset("t6_reset");
    drive_b(1, 0, 0); cycle("t6_card2");
    for (int i = 0; i < B_PL; i++) begin
      drive_b(1, 1, ref_digit(1, 32'(if_b.pin_ref), i)); cycle("t6_good");
    end
    check("t6_granted", 32'(if_b.state), 32'd3);
    drive_b(0, 0, 0); cycle("t6_out");

    // randomized traffic on both instances
    burst[0] = 0;
    burst[1] = 0;
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 99) do_reset("rnd_reset");
      for (int k = 0; k < 2; k++) begin
        c = ($urandom_range(0, 19) != 0);
        if (burst[k] > 0) begin
          burst[k]--;
          v = 1'b0;
        end else begin
          if ($urandom_range(0, 24) == 0) burst[k] = $urandom_range(10, 20);
          v = ($urandom_range(0, 1) == 1);
        end
        if ($urandom_range(0, 3) != 0)
          d = ref_digit(k, (k == 0) ? 32'(if_a.pin_ref) : 32'(if_b.pin_ref), m_match[k].size());
        else
          d = $urandom_range(0, (1 << d_w[k]) - 1);
        if (k == 0) begin
          drive_a(c, v, d);
          if ($urandom_range(0, 63) == 0) if_a.pin_ref = 16'($urandom);
        end else begin
          drive_b(c, v, d);
          if ($urandom_range(0, 63) == 0) if_b.pin_ref = 18'($urandom);
        end
      end
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
